ball_sprite_gen: RTL and testbench

Per-pixel ball sprite renderer for the pong video path. It sits between the VGA timing/game-logic stage and the ball sprite ROM. From the current scan coordinate and the frame-latched ball position and type, it derives the ROM offsets and ball select. It then takes the ROM's 16-bit RGB565 word back, applies a transparency key and composites the result over the incoming background pixel through a 2-stage pipeline with matching sync delay.

---
 rtl/ball_pkg.sv | 35 +++
 rtl/ball_box_hit.sv | 32 +++
 rtl/ball_sprite_gen.sv | 149 ++++++++++++++
 tb/tb_ball_sprite_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the pong ball sprite path.
package ball_pkg;

   typedef enum logic [1:0] {
      PINGPONG = 2'd0,
      SOCCER   = 2'd1,
      BASKET   = 2'd2
   } ball_type_e;

   localparam logic [6:0] SIZE_PINGPONG = 7'd20;
   localparam logic [6:0] SIZE_SOCCER   = 7'd40;
   localparam logic [6:0] SIZE_BASKET   = 7'd64;

   typedef logic [15:0] rgb565_t;

   localparam int unsigned PIPE_DEPTH = 2;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
   } sync_t;

   // Type codes 2 and 3 both select the basketball.
   function automatic logic [6:0] ball_size(input logic [1:0] bt);
      logic [6:0] size;
      case (bt)
         PINGPONG: size = SIZE_PINGPONG;
         SOCCER:   size = SIZE_SOCCER;
         default:  size = SIZE_BASKET;
      endcase
      return size;
   endfunction

endpackage

// File: rtl/ball_box_hit.sv
// Combinational ball bounding-box test and ROM offset generation.
module ball_box_hit
   import ball_pkg::*;
(
   input  logic       i_de,
   input  logic [9:0] i_x,
   input  logic [9:0] i_y,
   input  logic [9:0] i_bx,
   input  logic [9:0] i_by,
   input  logic [6:0] i_size,
   output logic       o_in_box,
   output logic [9:0] o_x_off,
   output logic [9:0] o_y_off
);

   logic [10:0] w_x_end;
   logic [10:0] w_y_end;
   logic        w_x_in;
   logic        w_y_in;

   // 11-bit end coordinates so a ball near the right/bottom edge clips instead of wrapping.
   assign w_x_end = {1'b0, i_bx} + {4'b0, i_size};
   assign w_y_end = {1'b0, i_by} + {4'b0, i_size};

   assign w_x_in  = (i_x >= i_bx) && ({1'b0, i_x} < w_x_end);
   assign w_y_in  = (i_y >= i_by) && ({1'b0, i_y} < w_y_end);

   assign o_in_box = i_de && w_x_in && w_y_in;
   assign o_x_off  = o_in_box ? (i_x - i_bx) : '0;
   assign o_y_off  = o_in_box ? (i_y - i_by) : '0;

endmodule

// File: rtl/ball_sprite_gen.sv
// Ball sprite renderer: frame-latched position, ROM addressing, keyed 2-stage compositing.
// Optional outline: define BALL_BBOX_EN.
module ball_sprite_gen
   import ball_pkg::*;
#(
   parameter rgb565_t KEY_COLOR  = 16'h0000,
   parameter rgb565_t BBOX_COLOR = 16'hF800
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        frame_start,
   input  logic [9:0]  x_pixel,
   input  logic [9:0]  y_pixel,
   input  logic        de_in,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [15:0] bg_rgb,
   input  logic [9:0]  ball_x,
   input  logic [9:0]  ball_y,
   input  logic [1:0]  ball_type,
   output logic [9:0]  x_offset,
   output logic [9:0]  y_offset,
   output logic [1:0]  rand_ball,
   input  logic [15:0] pixel_data,
   output logic [15:0] rgb_out,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic [12:0] ball_px_cnt
);

   logic [9:0]  r_bx;
   logic [9:0]  r_by;
   logic [1:0]  r_bt;

   logic        r_in_box_s1;
   rgb565_t     r_bg_s1;
   sync_t       r_sync_dly [PIPE_DEPTH];

   logic [12:0] r_cnt;

   logic        w_in_box;
   logic [9:0]  w_x_off;
   logic [9:0]  w_y_off;
   logic        w_opaque;
   logic        w_edge;
   logic        w_cnt_inc;
   logic [12:0] w_cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bx <= '0;
         r_by <= '0;
         r_bt <= '0;
      end else if (frame_start) begin
         r_bx <= ball_x;
         r_by <= ball_y;
         r_bt <= ball_type;
      end
   end

   ball_box_hit u_box_hit (
      .i_de     (de_in),
      .i_x      (x_pixel),
      .i_y      (y_pixel),
      .i_bx     (r_bx),
      .i_by     (r_by),
      .i_size   (ball_size(r_bt)),
      .o_in_box (w_in_box),
      .o_x_off  (w_x_off),
      .o_y_off  (w_y_off)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x_offset    <= '0;
         y_offset    <= '0;
         rand_ball   <= '0;
         r_in_box_s1 <= 1'b0;
         r_bg_s1     <= '0;
      end else begin
         x_offset    <= w_x_off;
         y_offset    <= w_y_off;
         rand_ball   <= r_bt;
         r_in_box_s1 <= w_in_box;
         r_bg_s1     <= bg_rgb;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            r_sync_dly[i] <= '0;
         end
      end else begin
         r_sync_dly[0] <= '{de: de_in, hs: hsync_in, vs: vsync_in};
         for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
            r_sync_dly[i] <= r_sync_dly[i-1];
         end
      end
   end

   assign de_out    = r_sync_dly[PIPE_DEPTH-1].de;
   assign hsync_out = r_sync_dly[PIPE_DEPTH-1].hs;
   assign vsync_out = r_sync_dly[PIPE_DEPTH-1].vs;

`ifdef BALL_BBOX_EN
   logic [6:0] w_last;
   // Stage-1 rand_ball carries the type the in-flight pixel was addressed with.
   assign w_last = ball_size(rand_ball) - 7'd1;
   assign w_edge = r_in_box_s1 &&
                   ((x_offset == '0) || (x_offset == {3'b0, w_last}) ||
                    (y_offset == '0) || (y_offset == {3'b0, w_last}));
`else
   assign w_edge = 1'b0;
`endif

   assign w_opaque  = r_in_box_s1 && (pixel_data != KEY_COLOR);
   assign w_cnt_inc = w_opaque && !w_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_out <= '0;
      end else if (!r_sync_dly[0].de) begin
         rgb_out <= '0;
      end else if (w_edge) begin
         rgb_out <= BBOX_COLOR;
      end else if (w_opaque) begin
         rgb_out <= pixel_data;
      end else begin
         rgb_out <= r_bg_s1;
      end
   end

   assign w_cnt_next = (w_cnt_inc && (r_cnt != '1)) ? r_cnt + 13'd1 : r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= '0;
         ball_px_cnt <= '0;
      end else if (frame_start) begin
         ball_px_cnt <= w_cnt_next;
         r_cnt       <= '0;
      end else begin
         r_cnt       <= w_cnt_next;
      end
   end

endmodule

// File: tb/tb_ball_sprite_gen.sv
// Directed vector bench for ball_sprite_gen (default build, no outline).
module tb_ball_sprite_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [9:0]  x_pixel = '0;
   logic [9:0]  y_pixel = '0;
   logic        de_in = 1'b0;
   logic        hsync_in = 1'b0;
   logic        vsync_in = 1'b0;
   logic [15:0] bg_rgb = '0;
   logic [9:0]  ball_x = '0;
   logic [9:0]  ball_y = '0;
   logic [1:0]  ball_type = '0;
   logic [9:0]  x_offset;
   logic [9:0]  y_offset;
   logic [1:0]  rand_ball;
   logic [15:0] pixel_data = '0;
   logic [15:0] rgb_out;
   logic        de_out;
   logic        hsync_out;
   logic        vsync_out;
   logic [12:0] ball_px_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   ball_sprite_gen #(
      .KEY_COLOR  (16'h0000),
      .BBOX_COLOR (16'hF800)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frame_start (frame_start),
      .x_pixel     (x_pixel),
      .y_pixel     (y_pixel),
      .de_in       (de_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .bg_rgb      (bg_rgb),
      .ball_x      (ball_x),
      .ball_y      (ball_y),
      .ball_type   (ball_type),
      .x_offset    (x_offset),
      .y_offset    (y_offset),
      .rand_ball   (rand_ball),
      .pixel_data  (pixel_data),
      .rgb_out     (rgb_out),
      .de_out      (de_out),
      .hsync_out   (hsync_out),
      .vsync_out   (vsync_out),
      .ball_px_cnt (ball_px_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [9:0]  bx;
      logic [9:0]  by;
      logic [1:0]  bt;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        de;
      logic        hs;
      logic        vs;
      logic [15:0] bg;
      logic [15:0] pix;
      logic [9:0]  ex;
      logic [9:0]  ey;
      logic [15:0] er;
   } vec_t;

   vec_t vt [13];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ball(input logic [9:0] bx, input logic [9:0] by, input logic [1:0] bt);
      ball_x      = bx;
      ball_y      = by;
      ball_type   = bt;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic drive(input logic [9:0] x, input logic [9:0] y, input logic de,
                        input logic [15:0] bg, input logic [15:0] pix);
      x_pixel    = x;
      y_pixel    = y;
      de_in      = de;
      bg_rgb     = bg;
      pixel_data = pix;
   endtask

   task automatic flush();
      de_in = 1'b0;
      step();
      step();
   endtask

   task automatic scan_box(input int unsigned n, input logic [15:0] pix);
      for (int unsigned yy = 0; yy < n; yy++) begin
         for (int unsigned xx = 0; xx < n; xx++) begin
            drive(10'(xx), 10'(yy), 1'b1, 16'h0F0F, pix);
            step();
         end
      end
   endtask

   initial begin
      //          bx   by   bt  x    y    de hs vs bg        pix       ex  ey  er
      vt[0]  = '{100, 50,  0, 105, 60,  1, 0, 0, 16'h1234, 16'h07E0, 5,  10, 16'h07E0};
      vt[1]  = '{100, 50,  0, 106, 61,  1, 1, 0, 16'h1234, 16'h0000, 6,  11, 16'h1234};
      vt[2]  = '{100, 50,  0, 120, 50,  1, 0, 1, 16'h5555, 16'hABCD, 0,  0,  16'h5555};
      vt[3]  = '{100, 50,  0, 119, 69,  1, 0, 0, 16'h5555, 16'h1111, 19, 19, 16'h1111};
      vt[4]  = '{100, 50,  0, 99,  50,  1, 0, 0, 16'h6666, 16'h1111, 0,  0,  16'h6666};
      vt[5]  = '{100, 50,  0, 100, 70,  1, 0, 0, 16'h7777, 16'h1111, 0,  0,  16'h7777};
      vt[6]  = '{100, 50,  0, 105, 60,  0, 1, 1, 16'h1234, 16'h07E0, 0,  0,  16'h0000};
      vt[7]  = '{620, 470, 2, 639, 479, 1, 0, 0, 16'h2222, 16'hF00F, 19, 9,  16'hF00F};
      vt[8]  = '{620, 470, 2, 0,   0,   1, 0, 0, 16'h2222, 16'hF00F, 0,  0,  16'h2222};
      vt[9]  = '{200, 100, 1, 239, 139, 1, 0, 0, 16'h3333, 16'h001F, 39, 39, 16'h001F};
      vt[10] = '{200, 100, 1, 240, 139, 1, 0, 0, 16'h3333, 16'h001F, 0,  0,  16'h3333};
      vt[11] = '{10,  10,  3, 73,  73,  1, 0, 0, 16'h4444, 16'h8421, 63, 63, 16'h8421};
      vt[12] = '{10,  10,  3, 74,  10,  1, 0, 0, 16'h4444, 16'h8421, 0,  0,  16'h4444};

      // Reset state
      step();
      step();
      check("rst_rgb", rgb_out, 16'h0);
      check("rst_xoff", 16'(x_offset), 16'h0);
      check("rst_de", 16'(de_out), 16'h0);
      check("rst_cnt", 16'(ball_px_cnt), 16'h0);
      reset = 1'b0;
      step();

      // Table-driven vectors
      for (int i = 0; i < 13; i++) begin
         set_ball(vt[i].bx, vt[i].by, vt[i].bt);
         drive(vt[i].x, vt[i].y, vt[i].de, vt[i].bg, vt[i].pix);
         hsync_in = vt[i].hs;
         vsync_in = vt[i].vs;
         step();
         check($sformatf("v%0d_xoff", i), 16'(x_offset), 16'(vt[i].ex));
         check($sformatf("v%0d_yoff", i), 16'(y_offset), 16'(vt[i].ey));
         check($sformatf("v%0d_rball", i), 16'(rand_ball), 16'(vt[i].bt));
         step();
         check($sformatf("v%0d_rgb", i), rgb_out, vt[i].er);
         check($sformatf("v%0d_de", i), 16'(de_out), 16'(vt[i].de));
         check($sformatf("v%0d_hs", i), 16'(hsync_out), 16'(vt[i].hs));
         check($sformatf("v%0d_vs", i), 16'(vsync_out), 16'(vt[i].vs));
      end
      hsync_in = 1'b0;
      vsync_in = 1'b0;

      // Frame latch: mid-frame change ignored, coincident pulse applies from next coordinate
      set_ball(100, 50, 0);
      ball_x = 300;
      drive(105, 60, 1'b1, 16'h1234, 16'h07E0);
      step();
      check("latch_mid_xoff", 16'(x_offset), 16'd5);
      step();
      check("latch_mid_rgb", rgb_out, 16'h07E0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("latch_coinc_xoff", 16'(x_offset), 16'd5);
      step();
      check("latch_new_xoff", 16'(x_offset), 16'd0);
      check("latch_inflight_rgb", rgb_out, 16'h07E0);
      drive(305, 60, 1'b1, 16'h1234, 16'h07E0);
      step();
      check("latch_new_hit_xoff", 16'(x_offset), 16'd5);

      // Pixel count: full soccer ball, no key pixels
      flush();
      set_ball(0, 0, 1);
      scan_box(50, 16'h1234);
      flush();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("cnt_soccer", 16'(ball_px_cnt), 16'd1600);

      // Opaque pixel reaching stage 2 on the frame_start edge is included
      drive(0, 0, 1'b1, 16'h0F0F, 16'h1234);
      step();
      de_in = 1'b0;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("cnt_same_cycle", 16'(ball_px_cnt), 16'd1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("cnt_cleared", 16'(ball_px_cnt), 16'd0);

      // Saturation: 2 x 4096 opaque pixels in one frame
      set_ball(0, 0, 2);
      scan_box(64, 16'h1234);
      scan_box(64, 16'h1234);
      flush();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("cnt_saturate", 16'(ball_px_cnt), 16'd8191);

      // Async reset mid-line
      drive(5, 5, 1'b1, 16'h0F0F, 16'h07E0);
      hsync_in = 1'b1;
      vsync_in = 1'b1;
      step();
      step();
      check("pre_rst_rgb", rgb_out, 16'h07E0);
      #2;
      reset = 1'b1;
      #1;
      check("arst_rgb", rgb_out, 16'h0);
      check("arst_xoff", 16'(x_offset), 16'h0);
      check("arst_yoff", 16'(y_offset), 16'h0);
      check("arst_rball", 16'(rand_ball), 16'h0);
      check("arst_de", 16'(de_out), 16'h0);
      check("arst_hs", 16'(hsync_out), 16'h0);
      check("arst_vs", 16'(vsync_out), 16'h0);
      check("arst_cnt", 16'(ball_px_cnt), 16'h0);
      #1;
      reset = 1'b0;
      hsync_in = 1'b0;
      vsync_in = 1'b0;
      drive(5, 10, 1'b1, 16'h0F0F, 16'h07E0);
      step();
      check("post_rst_xoff", 16'(x_offset), 16'd5);
      check("post_rst_yoff", 16'(y_offset), 16'd10);
      check("post_rst_rball", 16'(rand_ball), 16'd0);
      step();
      check("post_rst_rgb", rgb_out, 16'h07E0);
      drive(20, 10, 1'b1, 16'h0F0F, 16'h07E0);
      step();
      step();
      check("post_rst_edge_rgb", rgb_out, 16'h0F0F);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
